// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_pkg
//  Purpose  : Shared constants and types for the dsp_mac_pipe datapath:
//             OPMODE bit positions, Z-source encodings, default widths and
//             the post-adder control record that travels down the pipe.
//  Revision : 1.0  initial release
// ============================================================================
package dsp_pkg;

  // OPMODE bit positions
  localparam int c_op_pre_en   = 0;
  localparam int c_op_pre_sub  = 1;
  localparam int c_op_zsel_lo  = 2;
  localparam int c_op_zsel_hi  = 3;
  localparam int c_op_post_sub = 4;
  localparam int c_op_cin      = 5;

  // Default operand widths
  localparam int c_def_a_w = 18;
  localparam int c_def_b_w = 18;
  localparam int c_def_p_w = 48;

  // Post-adder Z source selection
  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_C    = 2'd1,
    Z_P    = 2'd2,
    Z_PCIN = 2'd3
  } zsel_e;

  // Post-adder controls; only these OPMODE bits are needed past stage 1
  typedef struct packed {
    logic  cin;
    logic  post_sub;
    zsel_e zsel;
  } post_ctl_t;

  // Takes the upper OPMODE field (bits 5..2) so bit indices stay absolute
  function automatic post_ctl_t decode_post(input logic [5:2] op_hi);
    post_ctl_t ctl;
    ctl.zsel     = zsel_e'(op_hi[c_op_zsel_hi:c_op_zsel_lo]);
    ctl.post_sub = op_hi[c_op_post_sub];
    ctl.cin      = op_hi[c_op_cin];
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_preadd_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_preadd_stage
//  Purpose  : B-source select, stage-1 B/D registers and the stage-2
//             pre-adder register. The pre-adder result wraps to B_W bits.
//  Ports    : clk, rst_n      clock, synchronous active-low reset
//             ce              clock enable (0 holds all registers)
//             i_b, i_bcin     direct and cascade B inputs
//             i_d             pre-adder D operand
//             i_pre_en        stage-1 PRE_EN (0: pass B through)
//             i_pre_sub       stage-1 PRE_SUB (1: D-B, 0: D+B)
//             o_bcout         stage-1 registered B
//             o_pre           stage-2 pre-adder result
//  Revision : 1.0  initial release
// ============================================================================
module dsp_preadd_stage #(
  parameter int    B_W     = 18,
  parameter string B_INPUT = "DIRECT"
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic [B_W-1:0] i_b,
  input  logic [B_W-1:0] i_bcin,
  input  logic [B_W-1:0] i_d,
  input  logic           i_pre_en,
  input  logic           i_pre_sub,
  output logic [B_W-1:0] o_bcout,
  output logic [B_W-1:0] o_pre
);

  localparam bit c_use_cascade = (B_INPUT == "CASCADE");

  logic [B_W-1:0] w_b_src;
  logic [B_W-1:0] r_b1;
  logic [B_W-1:0] r_d1;
  logic [B_W-1:0] w_pre;
  logic [B_W-1:0] r_pre2;

  assign w_b_src = c_use_cascade ? i_bcin : i_b;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b1 <= '0;
      r_d1 <= '0;
    end else if (ce) begin
      r_b1 <= w_b_src;
      r_d1 <= i_d;
    end
  end

  // Pre-adder; B_W-bit arithmetic gives the required wrap for free
  always_comb begin
    w_pre = r_b1;
    if (i_pre_en) begin
      w_pre = i_pre_sub ? (r_d1 - r_b1) : (r_d1 + r_b1);
    end
  end

  // Stage 2: pre-adder result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre2 <= '0;
    end else if (ce) begin
      r_pre2 <= w_pre;
    end
  end

  assign o_bcout = r_b1;
  assign o_pre   = r_pre2;

endmodule
`default_nettype wire

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_pipe
//  Purpose  : 4-stage pre-adder -> multiplier -> post-adder MAC with
//             valid/last tracking, per-frame accumulation with automatic
//             clear, and a sticky signed-overflow flag.
//  Ports    : CLK, RSTN        clock, synchronous active-low reset
//             CE               global enable, 0 stalls every register
//             IN_VALID/IN_LAST sample strobe and end-of-frame marker
//             OPMODE           per-sample mode, travels with its sample
//             A, B, D, BCIN    multiplier / pre-adder operands
//             C, PCIN          post-adder Z sources
//             CLR_OVF          clears the sticky OVF flag
//             BCOUT            stage-1 registered B
//             M                stage-3 product register
//             P, PCOUT         stage-4 result
//             CARRYOUT         unsigned carry/borrow of the post-adder
//             OUT_VALID        P updated, OUT_LAST: P is a frame result
//             OVF              sticky signed overflow
//  Revision : 1.0  initial release
// ============================================================================
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int    A_W     = c_def_a_w,
  parameter int    B_W     = c_def_b_w,
  parameter int    P_W     = c_def_p_w,
  parameter string B_INPUT = "DIRECT"
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               CE,
  input  logic               IN_VALID,
  input  logic               IN_LAST,
  input  logic [5:0]         OPMODE,
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  input  logic [B_W-1:0]     D,
  input  logic [B_W-1:0]     BCIN,
  input  logic [P_W-1:0]     C,
  input  logic [P_W-1:0]     PCIN,
  input  logic               CLR_OVF,
  output logic [B_W-1:0]     BCOUT,
  output logic [A_W+B_W-1:0] M,
  output logic [P_W-1:0]     P,
  output logic [P_W-1:0]     PCOUT,
  output logic               CARRYOUT,
  output logic               OUT_VALID,
  output logic               OUT_LAST,
  output logic               OVF
);

  localparam int c_m_w = A_W + B_W;

  // Stage 1
  logic [A_W-1:0]   r1_a;
  logic [P_W-1:0]   r1_c;
  logic [P_W-1:0]   r1_pcin;
  logic [5:0]       r1_opmode;
  logic             r1_valid;
  logic             r1_last;
  // Stage 2
  logic [A_W-1:0]   r2_a;
  logic [B_W-1:0]   w_pre2;
  logic [P_W-1:0]   r2_c;
  logic [P_W-1:0]   r2_pcin;
  post_ctl_t        r2_ctl;
  logic             r2_valid;
  logic             r2_last;
  // Stage 3
  logic signed [c_m_w-1:0] w_a_ext;
  logic signed [c_m_w-1:0] w_pre_ext;
  logic signed [c_m_w-1:0] w_prod;
  logic [c_m_w-1:0] r_m;
  logic [P_W-1:0]   r3_c;
  logic [P_W-1:0]   r3_pcin;
  post_ctl_t        r3_ctl;
  logic             r3_valid;
  logic             r3_last;
  // Stage 4
  logic [P_W-1:0]   w_z;
  logic [P_W-1:0]   w_m_ext;
  logic [P_W:0]     w_uns;
  logic [P_W-1:0]   w_res;
  logic             w_carry;
  logic             w_ovf;
  logic [P_W-1:0]   r_p;
  logic             r_carry;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_ovf;
  logic             r_last_seen;   // previous valid result closed a frame

  // --------------------------------------------------------------------------
  // Stage 1: operand and control capture (B/D are held in the pre-add stage)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r1_a      <= '0;
      r1_c      <= '0;
      r1_pcin   <= '0;
      r1_opmode <= '0;
      r1_valid  <= 1'b0;
      r1_last   <= 1'b0;
    end else if (CE) begin
      r1_a      <= A;
      r1_c      <= C;
      r1_pcin   <= PCIN;
      r1_opmode <= OPMODE;
      r1_valid  <= IN_VALID;
      r1_last   <= IN_VALID & IN_LAST;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: pre-adder (sub-module) plus delay of the remaining sample fields
  // --------------------------------------------------------------------------
  dsp_preadd_stage #(
    .B_W     (B_W),
    .B_INPUT (B_INPUT)
  ) u_preadd (
    .clk       (CLK),
    .rst_n     (RSTN),
    .ce        (CE),
    .i_b       (B),
    .i_bcin    (BCIN),
    .i_d       (D),
    .i_pre_en  (r1_opmode[c_op_pre_en]),
    .i_pre_sub (r1_opmode[c_op_pre_sub]),
    .o_bcout   (BCOUT),
    .o_pre     (w_pre2)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r2_a     <= '0;
      r2_c     <= '0;
      r2_pcin  <= '0;
      r2_ctl   <= '0;
      r2_valid <= 1'b0;
      r2_last  <= 1'b0;
    end else if (CE) begin
      r2_a     <= r1_a;
      r2_c     <= r1_c;
      r2_pcin  <= r1_pcin;
      r2_ctl   <= decode_post(r1_opmode[5:2]);
      r2_valid <= r1_valid;
      r2_last  <= r1_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: signed multiply at full width
  // --------------------------------------------------------------------------
  assign w_a_ext   = c_m_w'($signed(r2_a));
  assign w_pre_ext = c_m_w'($signed(w_pre2));
  assign w_prod    = w_a_ext * w_pre_ext;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_m      <= '0;
      r3_c     <= '0;
      r3_pcin  <= '0;
      r3_ctl   <= '0;
      r3_valid <= 1'b0;
      r3_last  <= 1'b0;
    end else if (CE) begin
      // M keeps the last valid product so bubbles do not disturb it
      if (r2_valid) begin
        r_m <= w_prod;
      end
      r3_c     <= r2_c;
      r3_pcin  <= r2_pcin;
      r3_ctl   <= r2_ctl;
      r3_valid <= r2_valid;
      r3_last  <= r2_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 4: post-adder
  // --------------------------------------------------------------------------
  assign w_m_ext = P_W'($signed(r_m));

  always_comb begin
    w_z = '0;
    case (r3_ctl.zsel)
      Z_ZERO:  w_z = '0;
      Z_C:     w_z = r3_c;
      // Accumulating onto a finished frame result starts a new frame at 0
      Z_P:     w_z = r_last_seen ? '0 : r_p;
      Z_PCIN:  w_z = r3_pcin;
      default: w_z = '0;
    endcase
  end

  // One (P_W+1)-bit unsigned operation yields both the wrapped result
  // and the carry/borrow bit
  always_comb begin
    if (r3_ctl.post_sub) begin
      w_uns = {1'b0, w_z} - {1'b0, w_m_ext} - {{P_W{1'b0}}, r3_ctl.cin};
    end else begin
      w_uns = {1'b0, w_z} + {1'b0, w_m_ext} + {{P_W{1'b0}}, r3_ctl.cin};
    end
  end

  assign w_res   = w_uns[P_W-1:0];
  assign w_carry = w_uns[P_W];

  // Signed overflow from operand/result signs. The carry-in cannot create
  // an overflow on its own when the operand signs make one impossible.
  always_comb begin
    if (r3_ctl.post_sub) begin
      w_ovf = (w_z[P_W-1] != w_m_ext[P_W-1]) && (w_res[P_W-1] != w_z[P_W-1]);
    end else begin
      w_ovf = (w_z[P_W-1] == w_m_ext[P_W-1]) && (w_res[P_W-1] != w_z[P_W-1]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_p         <= '0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_last_seen <= 1'b1;
    end else if (CE) begin
      r_out_valid <= r3_valid;
      if (r3_valid) begin
        r_p         <= w_res;
        r_carry     <= w_carry;
        r_out_last  <= r3_last;
        r_last_seen <= r3_last;
      end
    end
  end

  // Sticky overflow; a new overflow takes priority over a clear
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_ovf <= 1'b0;
    end else if (CE) begin
      if (r3_valid && w_ovf) begin
        r_ovf <= 1'b1;
      end else if (CLR_OVF) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign M         = r_m;
  assign P         = r_p;
  assign PCOUT     = r_p;
  assign CARRYOUT  = r_carry;
  assign OUT_VALID = r_out_valid;
  assign OUT_LAST  = r_out_last;
  assign OVF       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_mac_pipe
//  Purpose  : Self-checking bench for dsp_mac_pipe. A driver issues samples
//             and pushes arithmetic-model results into a queue; a monitor
//             pops and compares on every new OUT_VALID.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_pipe;

  localparam int A_W = 18;
  localparam int B_W = 18;
  localparam int P_W = 48;
  localparam int M_W = A_W + B_W;

  logic           CLK = 1'b0;
  logic           RSTN, CE, IN_VALID, IN_LAST, CLR_OVF;
  logic [5:0]     OPMODE;
  logic [A_W-1:0] A;
  logic [B_W-1:0] B, D, BCIN;
  logic [P_W-1:0] C, PCIN;
  logic [B_W-1:0] BCOUT;
  logic [M_W-1:0] M;
  logic [P_W-1:0] P, PCOUT;
  logic           CARRYOUT, OUT_VALID, OUT_LAST, OVF;

  dsp_mac_pipe dut (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .OPMODE(OPMODE), .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
    .CLR_OVF(CLR_OVF), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [P_W-1:0] p;
    logic           carry;
    logic           last;
    logic           ovf;
    int             issue_en;
  } exp_t;

  exp_t           exp_q[$];
  logic [P_W-1:0] out_p_log[$];
  logic           out_last_log[$];
  int             out_cyc_log[$];
  int             errors = 0;
  int             checks = 0;
  int             en_cnt = 0;   // enabled, non-reset edges so far
  int             cyc    = 0;   // all edges so far

  // reference-model state
  logic [P_W-1:0] mdl_p;
  logic           mdl_last_seen;
  logic           mdl_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    mdl_p         = '0;
    mdl_last_seen = 1'b1;
    mdl_ovf       = 1'b0;
  endtask

  // Plain-arithmetic reference of one valid sample
  task automatic model_step(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                            input logic [B_W-1:0] d, input logic [P_W-1:0] c,
                            input logic [P_W-1:0] pcin, input logic [5:0] opm,
                            input logic last, output exp_t e);
    longint sa, sb, sd, pre_full, pre, m, z, res, cin, lim, mask, zu, mu;
    logic [B_W-1:0] pre_w;
    logic [63:0]    res_u, tmp;
    logic           ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sd = longint'($signed(d));
    pre_full = opm[0] ? (opm[1] ? sd - sb : sd + sb) : sb;
    pre_w = pre_full[B_W-1:0];
    pre   = longint'($signed(pre_w));
    m     = sa * pre;
    cin   = opm[5] ? 1 : 0;
    case (opm[3:2])
      2'd0:    z = 0;
      2'd1:    z = longint'($signed(c));
      2'd2:    z = mdl_last_seen ? 0 : longint'($signed(mdl_p));
      default: z = longint'($signed(pcin));
    endcase
    res   = opm[4] ? (z - m - cin) : (z + m + cin);
    lim   = longint'(1) <<< (P_W - 1);
    ovf   = (res >= lim) || (res < -lim);
    res_u = res;
    mask  = (longint'(1) <<< P_W) - 1;
    zu    = z & mask;
    mu    = m & mask;
    if (opm[4]) begin
      e.carry = (zu < mu + cin);
    end else begin
      tmp     = zu + mu + cin;
      e.carry = tmp[P_W];
    end
    e.p           = res_u[P_W-1:0];
    e.last        = last;
    mdl_p         = e.p;
    mdl_last_seen = last;
    mdl_ovf       = mdl_ovf | ovf;
    e.ovf         = mdl_ovf;
    e.issue_en    = en_cnt;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  // Present a sample and queue its expected result; the caller ticks
  task automatic issue(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic [B_W-1:0] d, input logic [P_W-1:0] c,
                       input logic [P_W-1:0] pcin, input logic [5:0] opm,
                       input logic last);
    exp_t e;
    A = a; B = b; D = d; C = c; PCIN = pcin; OPMODE = opm;
    IN_VALID = 1'b1;
    IN_LAST  = last;
    model_step(a, b, d, c, pcin, opm, last, e);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    idle();
    CE = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    tick();
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compare every new output against the scoreboard
  // --------------------------------------------------------------------------
  initial begin
    logic ce_s, rst_s;
    exp_t e;
    forever begin
      @(posedge CLK);
      ce_s  = CE;
      rst_s = RSTN;
      cyc++;
      if (ce_s && rst_s) en_cnt++;
      @(negedge CLK);
      if (ce_s && rst_s && OUT_VALID) begin
        out_p_log.push_back(P);
        out_last_log.push_back(OUT_LAST);
        out_cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: OUT_VALID=1 P=0x%0h, required no output", P);
        end else begin
          e = exp_q.pop_front();
          chk("P",        64'(P),        64'(e.p));
          chk("PCOUT",    64'(PCOUT),    64'(e.p));
          chk("CARRYOUT", 64'(CARRYOUT), 64'(e.carry));
          chk("OUT_LAST", 64'(OUT_LAST), 64'(e.last));
          chk("OVF",      64'(OVF),      64'(e.ovf));
          chk("latency",  64'(en_cnt - e.issue_en), 64'd4);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n0, c0;
    logic [63:0] r64;
    RSTN = 1'b0; CE = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; CLR_OVF = 1'b0;
    OPMODE = '0; A = '0; B = '0; D = '0; BCIN = 18'h2aaaa; C = '0; PCIN = '0;
    model_reset();

    // Reset for 5 cycles, with CE low for the first two
    for (int i = 0; i < 5; i++) begin
      CE = (i >= 2);
      tick();
      chk("rst_P", 64'(P), 64'd0);
      chk("rst_M", 64'(M), 64'd0);
      chk("rst_flags", 64'({BCOUT, CARRYOUT, OUT_VALID, OUT_LAST, OVF}), 64'd0);
    end
    RSTN = 1'b1;
    CE   = 1'b1;

    // Pre-add then multiply: (3+2)*5
    n0 = out_p_log.size();
    issue(18'd5, 18'd2, 18'd3, '0, '0, 6'b000001, 1'b0);
    tick();
    chk("bcout", 64'(BCOUT), 64'd2);
    drain();
    chk("t2_count", 64'(out_p_log.size() - n0), 64'd1);
    if (out_p_log.size() > 0) chk("t2_P", 64'(out_p_log[$]), 64'd25);
    chk("t2_M", 64'(M), 64'd25);
    chk("t2_ovalid_low", 64'(OUT_VALID), 64'd0);

    // Pre-sub, Z=C, post-sub: 1000 - 10*(13-3); closes a frame
    issue(18'd10, 18'd3, 18'd13, 48'd1000, '0, 6'b010111, 1'b1);
    tick();
    drain();
    chk("t3_P", 64'(P), 64'd900);
    chk("t3_M", 64'(M), 64'd100);

    // Frame accumulation: 2*3 three times, then a fresh frame
    n0 = out_p_log.size();
    issue(18'd2, 18'd3, 18'd0, '0, '0, 6'b001000, 1'b0); tick();
    issue(18'd2, 18'd3, 18'd0, '0, '0, 6'b001000, 1'b0); tick();
    issue(18'd2, 18'd3, 18'd0, '0, '0, 6'b001000, 1'b1); tick();
    issue(18'd2, 18'd3, 18'd0, '0, '0, 6'b001000, 1'b0); tick();
    drain();
    chk("t4_count", 64'(out_p_log.size() - n0), 64'd4);
    if (out_p_log.size() >= n0 + 4) begin
      chk("t4_P0", 64'(out_p_log[n0]),     64'd6);
      chk("t4_P1", 64'(out_p_log[n0 + 1]), 64'd12);
      chk("t4_P2", 64'(out_p_log[n0 + 2]), 64'd18);
      chk("t4_L2", 64'(out_last_log[n0 + 2]), 64'd1);
      chk("t4_P3", 64'(out_p_log[n0 + 3]), 64'd6);
    end

    // Overflow: (2^47-1) + 1
    issue(18'd1, 18'd1, 18'd0, 48'h7fff_ffff_ffff, '0, 6'b000100, 1'b0); tick();
    drain();
    chk("t5_P", 64'(P), 64'h8000_0000_0000);
    chk("t5_OVF", 64'(OVF), 64'd1);
    issue(18'd1, 18'd1, 18'd0, '0, '0, 6'b000000, 1'b0); tick();
    drain();
    chk("t5_OVF_hold", 64'(OVF), 64'd1);
    CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
    mdl_ovf = 1'b0;
    chk("t5_OVF_clr", 64'(OVF), 64'd0);
    // Clear held while a new overflow lands: set wins, then clear applies
    CLR_OVF = 1'b1;
    issue(18'd1, 18'd1, 18'd0, 48'h7fff_ffff_ffff, '0, 6'b000100, 1'b0); tick();
    drain();
    CLR_OVF = 1'b0;
    mdl_ovf = 1'b0;
    chk("t5_OVF_after_clr", 64'(OVF), 64'd0);

    // Three-cycle stall mid-pipe stretches latency to 7 cycles
    c0 = cyc;
    issue(18'h3fff9, 18'd11, 18'd0, '0, '0, 6'b000000, 1'b0);
    tick();
    idle();
    tick();
    CE = 1'b0;
    tick(); tick(); tick();
    chk("t6_stall_hold", 64'(OUT_VALID), 64'd0);
    drain();
    if (out_cyc_log.size() > 0) chk("t6_stall_lat", 64'(out_cyc_log[$] - c0), 64'd7);
    chk("t6_stall_P", 64'(P), 64'hffff_ffff_ffb3);

    // Reset mid-frame flushes in-flight samples
    n0 = out_p_log.size();
    issue(18'd4, 18'd5, 18'd0, '0, '0, 6'b001000, 1'b0); tick();
    issue(18'd4, 18'd5, 18'd0, '0, '0, 6'b001000, 1'b0); tick();
    idle(); tick();
    RSTN = 1'b0;
    tick(); tick();
    exp_q.delete();
    model_reset();
    RSTN = 1'b1;
    chk("t6_rst_P", 64'(P), 64'd0);
    repeat (6) tick();
    chk("t6_flush_none", 64'(out_p_log.size() - n0), 64'd0);
    issue(18'd2, 18'd3, 18'd0, '0, '0, 6'b001000, 1'b0); tick();
    drain();
    chk("t6_new_frame", 64'(P), 64'd6);

    // Randomised traffic with random stalls
    for (int it = 0; it < 400; it++) begin
      BCIN = B_W'($urandom);
      if ($urandom_range(0, 99) < 70) begin
        r64 = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: C = 48'h7fff_ffff_fff0 + P_W'($urandom_range(0, 15));
          1: C = 48'h8000_0000_0000 + P_W'($urandom_range(0, 15));
          default: C = r64[P_W-1:0];
        endcase
        r64 = {$urandom, $urandom};
        issue(A_W'($urandom), B_W'($urandom), B_W'($urandom), C, r64[P_W-1:0],
              6'($urandom), ($urandom_range(0, 3) == 0));
        for (int k = 0; k < 20; k++) begin
          CE = (k >= 10) || ($urandom_range(0, 99) < 85);
          tick();
          if (CE) break;
        end
      end else begin
        idle();
        IN_LAST = 1'($urandom);
        CE = ($urandom_range(0, 99) < 85);
        tick();
      end
      idle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
